// File: rtl/blk_addr_alloc_arb.sv
// blk_addr_alloc_arb
//   Shared free-block allocator with a round-robin arbiter for the packet-cache
//   SRAM. Input controllers pulse a request per block they need. Grants hand out
//   block addresses from a circular free list, one requester per cycle. The
//   dequeue side returns addresses, and they are recycled into the list.
//
// Ports
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_addr_req      : per-port one-cycle request pulse
//   o_blk_addr      : granted block address (shared by all ports)
//   o_blk_addr_vld  : one-hot grant strobe, one cycle per grant
//   i_free_vld      : release strobe
//   i_free_addr     : released block address
//   o_free_cnt      : number of free blocks held
//   o_init_done     : free list has been filled after reset
//   o_empty         : free count is zero
//   o_err_ovf       : sticky, release dropped (list full or still initialising)
//   o_err_dup_req   : sticky, request pulse on a port already pending
module blk_addr_alloc_arb #(
  parameter int NUM_PORTS      = 16,
  parameter int BLK_ADDR_WIDTH = 11,
  parameter int NUM_BLK        = 2048,
  parameter int CNT_WIDTH      = BLK_ADDR_WIDTH + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_PORTS-1:0]      i_addr_req,
  output logic [BLK_ADDR_WIDTH-1:0] o_blk_addr,
  output logic [NUM_PORTS-1:0]      o_blk_addr_vld,
  input  logic                      i_free_vld,
  input  logic [BLK_ADDR_WIDTH-1:0] i_free_addr,
  output logic [CNT_WIDTH-1:0]      o_free_cnt,
  output logic                      o_init_done,
  output logic                      o_empty,
  output logic                      o_err_ovf,
  output logic                      o_err_dup_req
);

  localparam int PTR_W  = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(NUM_BLK);
  localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(NUM_BLK - 1);
  localparam logic [PORT_W-1:0]    PORT_LAST = PORT_W'(NUM_PORTS - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                    state_r;
  logic [BLK_ADDR_WIDTH-1:0] mem_r [NUM_BLK];
  logic [NUM_PORTS-1:0]      pending_r;
  logic [PORT_W-1:0]         rr_ptr_r;
  logic [PTR_W-1:0]          wr_ptr_r;
  logic [PTR_W-1:0]          rd_ptr_r;
  logic [PTR_W-1:0]          init_cnt_r;

  logic                      win_found_s;
  logic [PORT_W-1:0]         win_idx_s;
  logic [PORT_W:0]           cand_s;
  logic                      grant_s;
  logic [NUM_PORTS-1:0]      grant_oh_s;
  logic                      rel_ok_s;
  logic                      ovf_s;
  logic                      dup_s;
  logic [CNT_WIDTH-1:0]      cnt_nxt_s;

  // Round-robin search: first pending port at or above rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_s = {1'b0, rr_ptr_r} + (PORT_W+1)'(i);
      if (cand_s >= (PORT_W+1)'(NUM_PORTS)) begin
        cand_s = cand_s - (PORT_W+1)'(NUM_PORTS);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && pending_r[cand_s[PORT_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[PORT_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant/release qualification and error detection for this edge.
  always_comb begin
    grant_s  = (state_r == S_RUN) && win_found_s && (o_free_cnt != '0);
    rel_ok_s = (state_r == S_RUN) && i_free_vld && (o_free_cnt != CNT_FULL);
    ovf_s    = i_free_vld && !rel_ok_s;
    if (grant_s) begin
      grant_oh_s = NUM_PORTS'(1) << win_idx_s;
    end else begin
      grant_oh_s = '0;
    end
    // A re-pulse on the port being granted this edge is a fresh request.
    dup_s = |(i_addr_req & pending_r & ~grant_oh_s);
  end

  // Free count next value in run mode: grant and release cancel out.
  always_comb begin
    cnt_nxt_s = o_free_cnt;
    case ({grant_s, rel_ok_s})
      2'b10:   cnt_nxt_s = o_free_cnt - CNT_WIDTH'(1);
      2'b01:   cnt_nxt_s = o_free_cnt + CNT_WIDTH'(1);
      default: cnt_nxt_s = o_free_cnt;
    endcase
  end

  // Free-list storage: sequential fill during init, recycled addresses after.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (state_r == S_INIT)) begin
      mem_r[init_cnt_r] <= BLK_ADDR_WIDTH'(init_cnt_r);
    end else if (!i_rst && rel_ok_s) begin
      mem_r[wr_ptr_r] <= i_free_addr;
    end
  end

  // Control FSM, request capture, pointers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r        <= S_INIT;
      pending_r      <= '0;
      rr_ptr_r       <= '0;
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      init_cnt_r     <= '0;
      o_blk_addr     <= '0;
      o_blk_addr_vld <= '0;
      o_free_cnt     <= '0;
      o_init_done    <= 1'b0;
      o_empty        <= 1'b1;
      o_err_ovf      <= 1'b0;
      o_err_dup_req  <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~grant_oh_s) | i_addr_req;
      if (dup_s) begin
        o_err_dup_req <= 1'b1;
      end
      if (ovf_s) begin
        o_err_ovf <= 1'b1;
      end
      case (state_r)
        S_INIT: begin
          o_blk_addr_vld <= '0;
          init_cnt_r     <= init_cnt_r + PTR_W'(1);
          wr_ptr_r       <= wr_ptr_r + PTR_W'(1);
          o_free_cnt     <= o_free_cnt + CNT_WIDTH'(1);
          o_empty        <= 1'b0;
          if (init_cnt_r == PTR_LAST) begin
            state_r     <= S_RUN;
            o_init_done <= 1'b1;
          end
        end
        S_RUN: begin
          o_blk_addr_vld <= grant_oh_s;
          if (grant_s) begin
            o_blk_addr <= mem_r[rd_ptr_r];
            rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
            rr_ptr_r   <= (win_idx_s == PORT_LAST) ? '0 : win_idx_s + PORT_W'(1);
          end
          if (rel_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
          end
          o_free_cnt <= cnt_nxt_s;
          o_empty    <= (cnt_nxt_s == '0);
        end
        default: begin
          state_r <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blk_addr_alloc_arb.sv
// Testbench for blk_addr_alloc_arb: scoreboard of expected grants (port and
// address) fed from a reference free-list queue; a negedge monitor pops and
// compares every grant the DUT produces.
module tb_blk_addr_alloc_arb;

  localparam int NP  = 16;
  localparam int AW  = 11;
  localparam int NB  = 2048;
  localparam int CW  = AW + 1;

  logic          clk;
  logic          rst;
  logic [NP-1:0] addr_req;
  logic [AW-1:0] blk_addr;
  logic [NP-1:0] blk_addr_vld;
  logic          free_vld;
  logic [AW-1:0] free_addr;
  logic [CW-1:0] free_cnt;
  logic          init_done;
  logic          empty;
  logic          err_ovf;
  logic          err_dup_req;

  int n_checks = 0;
  int n_errors = 0;

  int fl_q[$];
  int exp_port_q[$];
  int exp_addr_q[$];
  int mon_p;
  int mon_a;

  blk_addr_alloc_arb #(
    .NUM_PORTS(NP), .BLK_ADDR_WIDTH(AW), .NUM_BLK(NB), .CNT_WIDTH(CW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_addr_req     (addr_req),
    .o_blk_addr     (blk_addr),
    .o_blk_addr_vld (blk_addr_vld),
    .i_free_vld     (free_vld),
    .i_free_addr    (free_addr),
    .o_free_cnt     (free_cnt),
    .o_init_done    (init_done),
    .o_empty        (empty),
    .o_err_ovf      (err_ovf),
    .o_err_dup_req  (err_dup_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input int port);
    exp_port_q.push_back(port);
    exp_addr_q.push_back(fl_q.pop_front());
  endtask

  task automatic reset_model();
    fl_q.delete();
    exp_port_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < NB; i++) fl_q.push_back(i);
  endtask

  task automatic pulse(input logic [NP-1:0] m);
    addr_req = m;
    tick();
    addr_req = '0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_port_q.size() != 0; i++) tick();
    check_eq("sb_drain", exp_port_q.size(), 0);
  endtask

  task automatic run_init();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!init_done && n < 3000);
    check_eq("init_latency", n, NB);
    check_eq("init_cnt", free_cnt, NB);
    check_eq("init_empty", empty, 0);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_addr", blk_addr, 0);
    check_eq("rst_vld", blk_addr_vld, 0);
    check_eq("rst_cnt", free_cnt, 0);
    check_eq("rst_done", init_done, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_ovf", err_ovf, 0);
    check_eq("rst_dup", err_dup_req, 0);
  endtask

  task automatic drain_port0(input int n);
    addr_req = 16'h0001;
    for (int i = 0; i < n; i++) begin
      exp_grant(0);
      tick();
    end
    addr_req = '0;
  endtask

  // Scoreboard monitor: every grant must match the head of the expected queue.
  always @(negedge clk) begin
    if (blk_addr_vld != '0) begin
      if (exp_port_q.size() == 0) begin
        check_eq("unexpected_grant", 32'(blk_addr_vld), 32'd0);
      end else begin
        mon_p = exp_port_q.pop_front();
        mon_a = exp_addr_q.pop_front();
        check_eq("grant_port", 32'(blk_addr_vld), 32'd1 << mon_p);
        check_eq("grant_addr", 32'(blk_addr), mon_a);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    addr_req  = '0;
    free_vld  = 1'b0;
    free_addr = '0;
    reset_model();
    tick();
    tick();
    check_reset_vals();
    rst = 1'b0;
    run_init();

    // Single request on port 3: grant visible one edge after capture.
    exp_grant(3);
    pulse(16'h0008);
    check_eq("lat_not_yet", blk_addr_vld, 16'h0000);
    tick();
    check_eq("p3_vld", blk_addr_vld, 16'h0008);
    check_eq("p3_addr", blk_addr, 0);
    check_eq("p3_cnt", free_cnt, NB - 1);
    exp_grant(3);
    pulse(16'h0008);
    wait_drain(10);
    check_eq("p3b_cnt", free_cnt, NB - 2);

    // Burst from all ports, interrupted by reset (rr_ptr starts at 4).
    for (int i = 0; i < NP; i++) exp_grant((4 + i) % NP);
    pulse(16'hFFFF);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_port_q.delete();
    exp_addr_q.delete();
    check_reset_vals();
    tick();
    rst = 1'b0;
    reset_model();
    run_init();

    // Full burst from a fresh rr_ptr: ports 0..15, addresses 0..15.
    for (int i = 0; i < NP; i++) exp_grant(i);
    pulse(16'hFFFF);
    wait_drain(40);
    exp_grant(2);
    exp_grant(5);
    pulse(16'h0024);
    wait_drain(10);
    check_eq("burst_cnt", free_cnt, NB - 18);

    // Drain down to 100 with back-to-back re-pulses (no duplicate error).
    drain_port0(NB - 18 - 100);
    wait_drain(20);
    check_eq("cnt_100", free_cnt, 100);
    check_eq("dup_clean", err_dup_req, 0);

    // Grant and release on the same edge keep the count.
    exp_grant(0);
    pulse(16'h0001);
    free_vld  = 1'b1;
    free_addr = 11'd0;
    fl_q.push_back(0);
    tick();
    free_vld = 1'b0;
    check_eq("same_edge_cnt", free_cnt, 100);
    wait_drain(10);

    // Drain to empty; new requests wait.
    drain_port0(100);
    wait_drain(20);
    check_eq("empty_cnt", free_cnt, 0);
    check_eq("empty_flag", empty, 1);
    pulse(16'h0042);
    for (int i = 0; i < 4; i++) tick();
    check_eq("empty_hold_vld", blk_addr_vld, 16'h0000);

    // Release 7: port 1 (next in rr order) gets it, one edge later.
    free_vld  = 1'b1;
    free_addr = 11'd7;
    fl_q.push_back(7);
    exp_grant(1);
    tick();
    free_vld = 1'b0;
    check_eq("no_bypass_vld", blk_addr_vld, 16'h0000);
    check_eq("rel_cnt", free_cnt, 1);
    tick();
    check_eq("rel7_vld", blk_addr_vld, 16'h0002);
    check_eq("rel7_addr", blk_addr, 7);
    free_vld  = 1'b1;
    free_addr = 11'd9;
    fl_q.push_back(9);
    exp_grant(6);
    tick();
    free_vld = 1'b0;
    tick();
    check_eq("rel9_vld", blk_addr_vld, 16'h0040);
    check_eq("rel9_addr", blk_addr, 9);
    wait_drain(5);
    check_eq("ovf_clean", err_ovf, 0);

    // Error flags: release while full, then a duplicate pulse.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_model();
    run_init();
    free_vld  = 1'b1;
    free_addr = 11'd5;
    tick();
    free_vld = 1'b0;
    check_eq("ovf_set", err_ovf, 1);
    check_eq("ovf_cnt", free_cnt, NB);
    check_eq("dup_not_yet", err_dup_req, 0);
    exp_grant(2);
    exp_grant(4);
    addr_req = 16'h0014;
    tick();
    addr_req = 16'h0010;
    tick();
    addr_req = '0;
    check_eq("dup_set", err_dup_req, 1);
    wait_drain(10);
    for (int i = 0; i < 5; i++) tick();
    check_eq("dup_cnt", free_cnt, NB - 2);
    check_eq("ovf_sticky", err_ovf, 1);
    check_eq("dup_sticky", err_dup_req, 1);
    rst = 1'b1;
    tick();
    check_eq("ovf_cleared", err_ovf, 0);
    check_eq("dup_cleared", err_dup_req, 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
